// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels.
// The receive path uses the same level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer for the UART transmitter: counts CLKS_PER_BIT cycles and
// pulses bit_tick on the last cycle of each bit period.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;

    assign bit_tick = enable && (count_q == LAST_CNT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            // Wraps on the terminal count so each period restarts from zero.
            if (count_q == LAST_CNT) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even
// parity (define UART_TX_PARITY_EN), stop bit. All outputs are registered.
//
// state  | meaning
// IDLE   | line idle high, waiting for tx_start
// START  | driving the start bit
// DATA   | shifting data bits out LSB first
// PARITY | driving even parity of the latched data (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit; exit raises tx_done for one cycle
module uart_tx_block
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_out
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 serial_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 timer_clear;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (timer_clear),
        .enable   (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        serial_d    = serial_out;
        busy_d      = tx_busy;
        done_d      = 1'b0;
        timer_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d     = START;
                    shreg_d     = tx_data;
                    serial_d    = UART_START_LEVEL;
                    busy_d      = 1'b1;
                    timer_clear = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d  = DATA;
                    serial_d = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = UART_STOP_LEVEL;
`endif
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        // Next bit is bit 1 of the register before this shift.
                        serial_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d  = STOP;
                    serial_d = UART_STOP_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d  = IDLE;
                    serial_d = UART_IDLE_LEVEL;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = UART_IDLE_LEVEL;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            serial_out <= UART_IDLE_LEVEL;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            serial_out <= serial_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured at accept since the shift register is consumed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_q <= 1'b0;
        end else if (state_q == IDLE && tx_start) begin
            parity_q <= ^tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block: expected line levels are queued per frame
// when a byte is sent and checked cycle by cycle as the frame is driven out.
module tb_uart_tx_block;

    localparam int N  = 10;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif
    localparam int F = NB * N;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       serial_out;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    uart_tx_block #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (N)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int k = 0; k < DB; k++) exp_q.push_back(d[k]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        push_frame(d);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("idle_serial", serial_out, 1'b1);
            check("idle_busy", tx_busy, 1'b0);
            check("idle_done", tx_done, 1'b0);
            @(negedge clk);
        end
    endtask

    // Checks one frame; ends at the tx_done negedge unless aborted by reset.
    task automatic check_frame(input int inject_at, input int abort_at);
        logic bits[NB];
        for (int i = 0; i < NB; i++) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty observed 0 entries expected %0d", NB);
                bits[i] = 1'b1;
            end else begin
                bits[i] = exp_q.pop_front();
            end
        end
        for (int c = 0; c < F; c++) begin
            if (c == abort_at) begin
                n_rst = 1'b0;
                #1;
                check("abort_serial", serial_out, 1'b1);
                check("abort_busy", tx_busy, 1'b0);
                check("abort_done", tx_done, 1'b0);
                return;
            end
            check("frame_serial", serial_out, bits[c / N]);
            check("frame_busy", tx_busy, 1'b1);
            check("frame_done", tx_done, 1'b0);
            if (c == inject_at) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        check("end_done", tx_done, 1'b1);
        check("end_busy", tx_busy, 1'b0);
        check("end_serial", serial_out, 1'b1);
    endtask

    initial begin
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial", serial_out, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        n_rst = 1'b1;
        check_idle(50);

        send(8'hA5);
        check_frame(-1, -1);
        @(negedge clk);
        check_idle(5);

        send(8'h3C);
        check_frame(40, -1);
        @(negedge clk);
        check_idle(5);

        send(8'h80);
        check_frame(-1, -1);
        send(8'h01);
        check_frame(-1, -1);
        @(negedge clk);
        check_idle(3);

        send(8'h00);
        check_frame(-1, 37);
        @(negedge clk);
        check("hold_serial", serial_out, 1'b1);
        n_rst = 1'b1;
        check_idle(5);
        send(8'h5A);
        check_frame(-1, -1);
        @(negedge clk);
        check_idle(3);

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        check_frame(-1, -1);
        @(negedge clk);
        check_idle(2);
        send(8'h03);
        check_frame(-1, -1);
        @(negedge clk);
        check_idle(2);
`endif

        check("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
